cache_axi_arbiter: RTL and testbench
====================================

CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_OFFSET_W, default 4, giving the number of low address bits ignored by the line-hazard compare (16-byte line).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- ic_rd_req / ic_rd_type / ic_rd_addr  in  1/3/32  ICache read request.
- ic_rd_rdy  out  1  ICache request accepted.
- ic_ret_valid / ic_ret_last / ic_ret_data  out  1/1/32  ICache return beat.
- dc_rd_req / dc_rd_type / dc_rd_addr  in  1/3/32  DCache read request.
- dc_rd_rdy  out  1  DCache request accepted.
- dc_ret_valid / dc_ret_last / dc_ret_data  out  1/1/32  DCache return beat.
- dc_wr_req / dc_wr_type / dc_wr_addr / dc_wr_wstrb / dc_wr_data  in  1/3/32/4/128  DCache write request.
- dc_wr_rdy / dc_wr_done  out  1/1  DCache write accepted / complete.
- rd_req / rd_type / rd_addr  out  1/3/32  bridge read request.
- rd_rdy  in  1  bridge read accept.
- ret_valid / ret_last / ret_data  in  1/1/32  bridge return beat.
- wr_req / wr_type / wr_addr / wr_wstrb / wr_data  out  1/3/32/4/128  bridge write request.
- wr_rdy / wr_done  in  1/1  bridge write accept / complete.

Function
REQ-003 Read state machine SHALL have states R_IDLE, R_WAIT_IC, R_WAIT_DC; one read outstanding at a time.
REQ-004 In R_IDLE, a requester is eligible when its rd_req=1 and it is not hazard-masked (REQ-010); the granted requester's type/addr SHALL be muxed combinationally onto rd_type/rd_addr with rd_req=1 in the same cycle (zero added latency).
REQ-005 Requester rd_rdy SHALL equal granted & bus rd_rdy in R_IDLE, 0 otherwise; on bus rd_req&rd_rdy the state SHALL move to R_WAIT_IC or R_WAIT_DC on the next edge.
REQ-006 In R_WAIT_x, rd_req SHALL be 0, and ret_valid/ret_last/ret_data SHALL be forwarded only to the owner; non-owner ret_* SHALL be 0.
REQ-007 On ret_valid&ret_last in R_WAIT_x the state SHALL return to R_IDLE next edge; a new grant is possible the following cycle.
REQ-008 ret_valid while in R_IDLE SHALL be dropped (not forwarded to either requester).
REQ-009 Write path: dc_wr_* SHALL pass combinationally to wr_*; dc_wr_rdy = wr_rdy & ~wr_busy; on wr_req&wr_rdy, wr_busy SHALL set and wr_line SHALL capture wr_addr[31:LINE_OFFSET_W]; wr_done SHALL clear wr_busy and pulse dc_wr_done for one cycle; wr_req SHALL be 0 while wr_busy.
REQ-010 A read SHALL be hazard-masked when addr[31:LINE_OFFSET_W] matches wr_line while wr_busy, or matches dc_wr_addr in a cycle where the write is being accepted.
REQ-011 wr_done and a masked read in the same cycle: read SHALL stay masked that cycle and be eligible next cycle.
REQ-012 Read and write channels SHALL operate concurrently when no hazard applies.
REQ-013 Requesters SHALL hold req/type/addr stable until their rd_rdy; the arbiter SHALL NOT latch request fields.

Reset
REQ-014 rst_n low SHALL asynchronously force R_IDLE, wr_busy=0, wr_line=0, last_grant=ICache; all outputs SHALL be 0 during reset.
REQ-015 Reset mid-transaction SHALL abandon the transaction; late return beats are dropped per REQ-008 and a late wr_done SHALL be ignored.

Configuration
REQ-016 With ARB_ROUND_ROBIN_EN defined, when both are eligible the one not in last_grant SHALL win and last_grant SHALL update on each accepted read.
REQ-017 Without ARB_ROUND_ROBIN_EN, DCache SHALL always win contention; last_grant logic SHALL be absent.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Both req same cycle, rd_rdy=1, default config -> DCache granted (dc_rd_rdy=1, ic_rd_rdy=0), rd_addr=dc_rd_addr.
- ARB_ROUND_ROBIN_EN, both continuously requesting, 4 reads -> grants DC, IC, DC, IC.
- ICache line read, 4 beats ret_data 0x11,0x22,0x33,0x44, last on 4th -> ic_ret_* mirror beats, dc_ret_valid=0, R_IDLE after 4th.
- Write to 0x1000_0010 accepted, DCache read 0x1000_001C -> dc_rd_rdy=0 until cycle after wr_done; read to 0x1000_0020 proceeds concurrently.
- Second write while wr_busy -> dc_wr_rdy=0, wr_req=0 until wr_done.
- rst_n low during R_WAIT_DC, then ret_valid -> no dc_ret_valid, state R_IDLE, outputs 0.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter
//   Shares one read/write bridge between an ICache and a DCache.
//   Read side: one outstanding read. Grant mux is combinational, so it adds
//   no latency. Return beats go only to the owner of the outstanding read.
//   Write side: DCache writes pass straight through. One write may be in
//   flight at a time. Reads that hit the line being written are held off
//   until the cycle after wr_done.
//
// Parameters:
//   LINE_OFFSET_W - low address bits ignored by the line-hazard compare.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ic_rd_* / ic_ret_*               ICache read request / return beats
//   dc_rd_* / dc_ret_*               DCache read request / return beats
//   dc_wr_*                          DCache write request, rdy, done pulse
//   rd_* / ret_*                     bridge read request / return beats
//   wr_*                             bridge write request, rdy, done
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, contended grants alternate. The
//   requester that was not granted last time wins. When undefined, the
//   DCache always wins contention.
module cache_axi_arbiter #(
    parameter int LINE_OFFSET_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic         ic_ret_last,
    output logic [31:0]  ic_ret_data,
    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic         dc_ret_last,
    output logic [31:0]  dc_ret_data,
    input  logic         dc_wr_req,
    input  logic [2:0]   dc_wr_type,
    input  logic [31:0]  dc_wr_addr,
    input  logic [3:0]   dc_wr_wstrb,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,
    output logic         dc_wr_done,
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_wstrb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy,
    input  logic         wr_done
);
    localparam int LINE_W = 32 - LINE_OFFSET_W;

    typedef enum logic [1:0] {R_IDLE, R_WAIT_IC, R_WAIT_DC} rd_state_t;

    rd_state_t          r_state;
    logic               r_wr_busy;
    logic [LINE_W-1:0]  r_wr_line;

    logic w_idle, w_wr_acc, w_rd_acc;
    logic w_ic_mask, w_dc_mask, w_ic_elig, w_dc_elig, w_gnt_ic, w_gnt_dc;
    logic w_own_ic, w_own_dc;

    assign w_idle   = (r_state == R_IDLE);
    // Outputs are combinational from inputs, so every path is gated with
    // rst_n. This keeps all outputs at 0 while reset is held.
    assign w_wr_acc = rst_n & dc_wr_req & wr_rdy & ~r_wr_busy;

    // A read is masked if it targets the in-flight write line, or the line
    // of a write being accepted this very cycle. r_wr_busy is still set in
    // the wr_done cycle, so the mask lifts one cycle after wr_done.
    assign w_ic_mask = (r_wr_busy && ic_rd_addr[31:LINE_OFFSET_W] == r_wr_line) ||
                       (w_wr_acc  && ic_rd_addr[31:LINE_OFFSET_W] == dc_wr_addr[31:LINE_OFFSET_W]);
    assign w_dc_mask = (r_wr_busy && dc_rd_addr[31:LINE_OFFSET_W] == r_wr_line) ||
                       (w_wr_acc  && dc_rd_addr[31:LINE_OFFSET_W] == dc_wr_addr[31:LINE_OFFSET_W]);

    assign w_ic_elig = rst_n & w_idle & ic_rd_req & ~w_ic_mask;
    assign w_dc_elig = rst_n & w_idle & dc_rd_req & ~w_dc_mask;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_dc: 0 = ICache was granted last (reset value), 1 = DCache.
    logic r_last_dc;
    assign w_gnt_dc = w_dc_elig & (~w_ic_elig | ~r_last_dc);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_last_dc <= 1'b0;
        else if (w_rd_acc) r_last_dc <= w_gnt_dc;
    end
`else
    assign w_gnt_dc = w_dc_elig;
`endif
    assign w_gnt_ic = w_ic_elig & ~w_gnt_dc;

    assign rd_req    = w_gnt_ic | w_gnt_dc;
    assign rd_type   = w_gnt_dc ? dc_rd_type : (w_gnt_ic ? ic_rd_type : 3'd0);
    assign rd_addr   = w_gnt_dc ? dc_rd_addr : (w_gnt_ic ? ic_rd_addr : 32'd0);
    assign ic_rd_rdy = w_gnt_ic & rd_rdy;
    assign dc_rd_rdy = w_gnt_dc & rd_rdy;
    assign w_rd_acc  = rd_req & rd_rdy;

    // Beats that arrive in R_IDLE have no owner and are dropped here.
    // This includes late beats of a transaction that a reset abandoned.
    assign w_own_ic     = (r_state == R_WAIT_IC);
    assign w_own_dc     = (r_state == R_WAIT_DC);
    assign ic_ret_valid = w_own_ic & ret_valid;
    assign ic_ret_last  = w_own_ic & ret_last;
    assign ic_ret_data  = w_own_ic ? ret_data : 32'd0;
    assign dc_ret_valid = w_own_dc & ret_valid;
    assign dc_ret_last  = w_own_dc & ret_last;
    assign dc_ret_data  = w_own_dc ? ret_data : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            case (r_state)
                R_IDLE:    if (w_rd_acc) r_state <= w_gnt_dc ? R_WAIT_DC : R_WAIT_IC;
                R_WAIT_IC,
                R_WAIT_DC: if (ret_valid && ret_last) r_state <= R_IDLE;
                default:   r_state <= R_IDLE;
            endcase
        end
    end

    // Write channel: pass-through, with a single in-flight tracker.
    assign wr_req     = rst_n & dc_wr_req & ~r_wr_busy;
    assign wr_type    = rst_n ? dc_wr_type  : 3'd0;
    assign wr_addr    = rst_n ? dc_wr_addr  : 32'd0;
    assign wr_wstrb   = rst_n ? dc_wr_wstrb : 4'd0;
    assign wr_data    = rst_n ? dc_wr_data  : 128'd0;
    assign dc_wr_rdy  = rst_n & wr_rdy & ~r_wr_busy;
    // wr_done is ignored unless a write is in flight. This covers a late
    // done after reset.
    assign dc_wr_done = rst_n & wr_done & r_wr_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_busy <= 1'b0;
            r_wr_line <= '0;
        end else if (w_wr_acc) begin
            r_wr_busy <= 1'b1;
            r_wr_line <= dc_wr_addr[31:LINE_OFFSET_W];
        end else if (wr_done && r_wr_busy) begin
            r_wr_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter. It covers reset, the grant policy
// (default or round-robin, chosen by build), line refill forwarding, write
// hazard masking, and reset during an outstanding read.
module tb_cache_axi_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_rd_req, dc_rd_req, dc_wr_req;
    logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
    logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic [3:0]   dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [31:0]  ic_ret_data;
    logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0]  dc_ret_data;
    logic         dc_wr_rdy, dc_wr_done;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, ret_data, wr_addr;
    logic         wr_req, wr_rdy, wr_done;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_dc;

    cache_axi_arbiter #(.LINE_OFFSET_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data),
        .dc_wr_rdy(dc_wr_rdy), .dc_wr_done(dc_wr_done),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ic_rd_req = 1; ic_rd_type = 3'd4; ic_rd_addr = 32'h2000_0000;
        dc_rd_req = 1; dc_rd_type = 3'd4; dc_rd_addr = 32'h3000_0040;
        dc_wr_req = 1; dc_wr_type = 3'd4; dc_wr_addr = 32'h4000_0000;
        dc_wr_wstrb = 4'hF; dc_wr_data = {4{32'hDEAD_BEEF}};
        rd_rdy = 1; ret_valid = 1; ret_last = 1; ret_data = 32'h55;
        wr_rdy = 1; wr_done = 1;
        #2;
        // ---- outputs held at 0 during reset ----
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_ic_rd_rdy", ic_rd_rdy, 0);
        chk("rst_dc_rd_rdy", dc_rd_rdy, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_dc_wr_rdy", dc_wr_rdy, 0);
        chk("rst_dc_wr_done", dc_wr_done, 0);
        chk("rst_ic_ret_valid", ic_ret_valid, 0);
        chk("rst_dc_ret_data", dc_ret_data, 0);
        ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
        ret_valid = 0; ret_last = 0; ret_data = 0; wr_done = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---- contention: 4 reads with both caches requesting continuously ----
        ic_rd_req = 1; ic_rd_type = 3'd4; ic_rd_addr = 32'h2000_0000;
        dc_rd_req = 1; dc_rd_type = 3'd2; dc_rd_addr = 32'h3000_0040;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dc = (k % 2 == 0);
`else
            exp_dc = 1'b1;
`endif
            #1;
            chk("arb_rd_req", rd_req, 1);
            chk("arb_dc_rd_rdy", dc_rd_rdy, exp_dc);
            chk("arb_ic_rd_rdy", ic_rd_rdy, !exp_dc);
            chk("arb_rd_addr", rd_addr, exp_dc ? 32'h3000_0040 : 32'h2000_0000);
            chk("arb_rd_type", rd_type, exp_dc ? 3'd2 : 3'd4);
            tick();
            ret_valid = 1; ret_last = 1; ret_data = 32'hA0 + k;
            #1;
            chk("wait_rd_req", rd_req, 0);
            chk("wait_own_valid", exp_dc ? dc_ret_valid : ic_ret_valid, 1);
            chk("wait_own_data", exp_dc ? dc_ret_data : ic_ret_data, 32'hA0 + k);
            chk("wait_other_valid", exp_dc ? ic_ret_valid : dc_ret_valid, 0);
            tick();
            ret_valid = 0; ret_last = 0; ret_data = 0;
        end
        ic_rd_req = 0; dc_rd_req = 0;

        // ---- ICache 4-beat line refill ----
        ic_rd_req = 1; ic_rd_addr = 32'h0000_1000;
        #1;
        chk("ic_line_rdy", ic_rd_rdy, 1);
        tick();
        ic_rd_req = 0;
        for (int b = 0; b < 4; b++) begin
            ret_valid = 1; ret_last = (b == 3); ret_data = 32'h11 * (b + 1);
            #1;
            chk("ic_beat_valid", ic_ret_valid, 1);
            chk("ic_beat_data", ic_ret_data, 32'h11 * (b + 1));
            chk("ic_beat_last", ic_ret_last, (b == 3));
            chk("ic_beat_dc_valid", dc_ret_valid, 0);
            chk("ic_beat_rd_req", rd_req, 0);
            tick();
        end
        // A stray beat in idle is dropped, and a new request is granted at once.
        ret_valid = 1; ret_last = 1; ret_data = 32'h99;
        dc_rd_req = 1; dc_rd_addr = 32'h3000_0080;
        #1;
        chk("idle_drop_ic", ic_ret_valid, 0);
        chk("idle_drop_dc", dc_ret_valid, 0);
        chk("idle_regrant", dc_rd_rdy, 1);
        tick();
        ret_valid = 1; ret_last = 1; ret_data = 32'h77;
        tick();
        ret_valid = 0; ret_last = 0; ret_data = 0; dc_rd_req = 0;

        // ---- write hazard ----
        dc_wr_req = 1; dc_wr_addr = 32'h1000_0010; dc_wr_wstrb = 4'hA;
        dc_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        dc_rd_req = 1; dc_rd_addr = 32'h1000_001C;
        #1;
        chk("wr_accept_rdy", dc_wr_rdy, 1);
        chk("wr_pass_req", wr_req, 1);
        chk("wr_pass_addr", wr_addr, 32'h1000_0010);
        chk("wr_pass_wstrb", wr_wstrb, 4'hA);
        chk("wr_pass_data", wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("haz_same_cycle_rdy", dc_rd_rdy, 0);
        chk("haz_same_cycle_rd_req", rd_req, 0);
        tick();
        // Busy. A second write must wait.
        dc_wr_addr = 32'h2000_0000;
        #1;
        chk("busy_dc_wr_rdy", dc_wr_rdy, 0);
        chk("busy_wr_req", wr_req, 0);
        chk("haz_busy_rdy", dc_rd_rdy, 0);
        // A read to another line proceeds concurrently.
        ic_rd_req = 1; ic_rd_addr = 32'h1000_0020;
        #1;
        chk("conc_ic_rdy", ic_rd_rdy, 1);
        chk("conc_rd_addr", rd_addr, 32'h1000_0020);
        tick();
        ic_rd_req = 0; ret_valid = 1; ret_last = 1; ret_data = 32'hC0C0;
        #1;
        chk("conc_ic_ret", ic_ret_data, 32'hC0C0);
        tick();
        ret_valid = 0; ret_last = 0; ret_data = 0;
        #1;
        chk("haz_still_masked", dc_rd_rdy, 0);
        tick();
        wr_done = 1;
        #1;
        chk("done_pulse", dc_wr_done, 1);
        chk("done_cycle_masked", dc_rd_rdy, 0);
        chk("done_cycle_wr_rdy", dc_wr_rdy, 0);
        tick();
        wr_done = 0;
        #1;
        chk("after_done_rd_rdy", dc_rd_rdy, 1);
        chk("after_done_rd_addr", rd_addr, 32'h1000_001C);
        chk("after_done_pulse", dc_wr_done, 0);
        chk("second_wr_rdy", dc_wr_rdy, 1);
        tick();
        // Now in R_WAIT_DC with the second write in flight.
        dc_rd_req = 0; dc_wr_req = 0;

        // ---- reset during R_WAIT_DC ----
        #2;
        rst_n = 1'b0;
        #1;
        ret_valid = 1; ret_last = 1; ret_data = 32'hBAD0;
        #1;
        chk("midrst_dc_ret_valid", dc_ret_valid, 0);
        chk("midrst_dc_ret_data", dc_ret_data, 0);
        chk("midrst_rd_req", rd_req, 0);
        tick();
        rst_n = 1'b1;
        wr_done = 1;
        #1;
        chk("late_ret_dropped", dc_ret_valid, 0);
        chk("late_wr_done_ignored", dc_wr_done, 0);
        ic_rd_req = 1; ic_rd_addr = 32'h0000_2000;
        #1;
        chk("post_rst_idle_grant", ic_rd_rdy, 1);
        tick();
        ic_rd_req = 0; ret_valid = 0; ret_last = 0; wr_done = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
